result_serializer: RTL

- Stage directly downstream of Control_RW_Flow in the binary calculator.
- On a TxData strobe it latches the parallel result word and shifts it out MSB-first on a single serial line, holding each bit for a programmable number of clock cycles.
- Returns a one-cycle tx_done pulse to the controller when the frame is complete.
- Reports busy so the controller does not restart it mid-frame.

---
 rtl/calc_pkg.sv | 9 +
 rtl/bit_timer.sv | 27 ++
 rtl/result_serializer.sv | 94 +++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and default sizes for the binary calculator datapath.
package calc_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

    localparam int CALC_DATA_W     = 8;
    localparam int CALC_BIT_CYCLES = 4;

endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts clock cycles within one serial bit and flags the last one.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;

    assign bit_tick = en && (cyc_cnt_q == LAST);

    // Wrap on the last cycle of a bit; with one cycle per bit the counter stays at 0.
    always_comb cyc_cnt_d = (clear || bit_tick) ? '0 : en ? cyc_cnt_q + 1'b1 : cyc_cnt_q;

    // Cycle counter register.
    always_ff @(posedge clk or negedge reset)
        if (!reset) cyc_cnt_q <= '0;
        else        cyc_cnt_q <= cyc_cnt_d;

endmodule

// File: rtl/result_serializer.sv
// result_serializer: latches the result word on TxData and shifts it out MSB-first.
// Optional even-parity bit after the LSB when CALC_SER_PARITY_EN is defined.
module result_serializer
    import calc_pkg::*;
#(
    parameter int DATA_W     = CALC_DATA_W,
    parameter int BIT_CYCLES = CALC_BIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_data,
    input  logic [DATA_W-1:0] data_in,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              tx_done
);

`ifdef CALC_SER_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1;
`else
    localparam int FRAME_BITS = DATA_W;
`endif
    localparam int BW = $clog2(DATA_W + 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    ser_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, frame_word;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  dout_q, dout_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic                  bit_tick, load, step;

`ifdef CALC_SER_PARITY_EN
    assign frame_word = {data_in, ^data_in};
`else
    assign frame_word = data_in;
`endif

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == SHIFT),
        .clear    (state_q != SHIFT),
        .bit_tick (bit_tick)
    );

    // Next state: start from IDLE on a strobe, leave SHIFT after the last bit, DONE lasts one cycle.
    always_comb
        state_d = (state_q == IDLE)  ? (tx_data ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? ((bit_tick && bit_cnt_q == LAST_BIT) ? DONE : SHIFT) :
                  IDLE;

    // Datapath: load the frame on an accepted start, shift and count on every bit boundary.
    always_comb begin
        load      = (state_q == IDLE) && tx_data;
        step      = (state_q == SHIFT) && bit_tick;
        shift_d   = load ? frame_word : step ? shift_q << 1 : shift_q;
        bit_cnt_d = load ? '0 : step ? bit_cnt_q + 1'b1 : bit_cnt_q;
    end

    // Outputs are decoded from the next state so they appear registered in the cycle they describe.
    always_comb begin
        dout_d  = (state_d == SHIFT) && shift_d[FRAME_BITS-1];
        valid_d = (state_d == SHIFT);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    // State, datapath and output registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule
